// File: rtl/fetch_buffer_unit_if.sv
// Instruction-fetch bundle: imem generic bus, redirect/halt controls and decode handshake.
interface fetch_buffer_unit_if;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_busy;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;

  // Fetch unit side
  modport master (
    output imem_ren, imem_addr, instr_valid, instr, instr_pc, instr_fault,
    input  imem_busy, imem_rdata, redirect, redirect_pc, halt, instr_ready
  );

  // Environment side (memory, pipeline control, decode)
  modport slave (
    input  imem_ren, imem_addr, instr_valid, instr, instr_pc, instr_fault,
    output imem_busy, imem_rdata, redirect, redirect_pc, halt, instr_ready
  );
endinterface

// File: rtl/fetch_buffer_unit.sv
// Fetch front end: PC generation, imem read sequencing, instruction FIFO toward decode,
// and redirect handling including discard of a read still in flight.
module fetch_buffer_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0200,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                  CLK,
  input logic                  nRST,
  fetch_buffer_unit_if.master  bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        drop_pc_q, drop_pc_d;
  logic               halt_fault_q, halt_fault_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

  logic [31:0]        data_mem_q  [FIFO_DEPTH];
  logic [31:0]        pc_mem_q    [FIFO_DEPTH];
  logic               fault_mem_q [FIFO_DEPTH];

  logic               done;
  logic               deq;
  logic               room;
  logic [CNT_W-1:0]   cnt_after;
  logic               enq;
  logic [31:0]        enq_data;
  logic               enq_fault;

  assign done      = (state_q != IDLE) && !bus.imem_busy;
  assign deq       = (count_q != '0) && bus.instr_ready && !bus.redirect;
  assign room      = count_q < CNT_W'(FIFO_DEPTH);
  assign cnt_after = count_q + CNT_W'(1) - CNT_W'(deq);

  assign bus.imem_ren    = (state_q != IDLE);
  assign bus.imem_addr   = {pc_q[31:2], 2'b00};
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr       = data_mem_q[rd_ptr_q];
  assign bus.instr_pc    = pc_mem_q[rd_ptr_q];
  assign bus.instr_fault = fault_mem_q[rd_ptr_q];

  // Next-state: fetch sequencing, redirect priority and FIFO bookkeeping
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_pc_d    = drop_pc_q;
    halt_fault_d = halt_fault_q;
    enq          = 1'b0;
    enq_data     = '0;
    enq_fault    = 1'b0;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
        end else if (!bus.halt && room && !halt_fault_q) begin
          if (pc_q[1:0] != 2'b00) begin
            // Misaligned PC: report it through the FIFO instead of touching the bus
            enq          = 1'b1;
            enq_fault    = 1'b1;
            halt_fault_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus.redirect) begin
          if (done) begin
            pc_d    = bus.redirect_pc;
            state_d = IDLE;
          end else begin
            drop_pc_d = bus.redirect_pc;
            state_d   = DROP;
          end
        end else if (done) begin
          enq      = 1'b1;
          enq_data = bus.imem_rdata;
          pc_d     = pc_q + 32'd4;
          if (!bus.halt && (cnt_after < CNT_W'(FIFO_DEPTH)) && (pc_d[1:0] == 2'b00)) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        // Bus request must complete with its original address; the data is thrown away
        if (bus.redirect) begin
          drop_pc_d = bus.redirect_pc;
        end
        if (done) begin
          pc_d    = bus.redirect ? bus.redirect_pc : drop_pc_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.redirect) begin
      halt_fault_d = 1'b0;
      count_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Control and pointer registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drop_pc_q    <= '0;
      halt_fault_q <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_pc_q    <= drop_pc_d;
      halt_fault_q <= halt_fault_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // FIFO entry storage
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i]  <= '0;
        pc_mem_q[i]    <= '0;
        fault_mem_q[i] <= 1'b0;
      end
    end else if (enq) begin
      data_mem_q[wr_ptr_q]  <= enq_data;
      pc_mem_q[wr_ptr_q]    <= pc_q;
      fault_mem_q[wr_ptr_q] <= enq_fault;
    end
  end

endmodule
